mux_arb_n: RTL and testbench
============================

// Module: mux_arb_n
// PURPOSE
//  Parametrised N:1 data multiplexer with a registered output and valid/ready handshakes.
//  Successor to the fixed 2:1/4:1 muxes: it adds a runtime choice of fixed-select or
//  round-robin arbitration, and packet locking driven by in_last.
//  Merges multi-source traffic (write-back ports, memory requesters) onto one 32-bit path.
// PARAMETERS
//  WIDTH  32             data width per channel
//  N      4              number of input channels, >=2
//  SEL_W  $clog2(N)      width of sel/out_src (derived; do not override)
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          synchronous, active-high reset
//  rr_en      in   1          1 = round-robin arbitration; 0 = fixed select via sel
//  sel        in   SEL_W      fixed-mode channel index; sampled only when unlocked
//  in_data    in   N*WIDTH    channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   N          per-channel data valid
//  in_last    in   N          per-channel end-of-packet; 1 = single-beat packet
//  in_ready   out  N          per-channel accept; at most one bit high
//  out_data   out  WIDTH      registered selected data
//  out_src    out  SEL_W      index of the channel that produced out_data
//  out_last   out  1          registered copy of the accepted in_last
//  out_valid  out  1          output register holds data
//  out_ready  in   1          downstream accept
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_src=0, out_last=0, rr_ptr=0, state=IDLE.
//    in_ready is all 0 during the reset cycle.
//  - Reset mid-packet: the lock is dropped and the output register is emptied; no beat is kept.
//  - Output-register load condition: ld = ~out_valid | out_ready.
//  - in_ready[g] = ld & grant_vld & (g == grant). in_ready is combinational.
//  - A transfer on channel g occurs when in_valid[g] & in_ready[g].
//  - Latency: accepted beat appears on out_* the next cycle; full throughput, 1 beat/clk.
//  - While out_valid & ~out_ready: out_* hold stable and every in_ready is 0.
//  - If ld with no transfer: out_valid <= 0 at the next edge.
//  - FSM states:
//    - IDLE: grant is computed every cycle.
//    - LOCK: grant = lock_ch regardless of rr_en/sel and regardless of other in_valid.
//  - FSM transitions:
//    - IDLE->LOCK on a transfer with in_last=0; lock_ch <= g.
//    - LOCK->IDLE on a transfer with in_last=1.
//    - A transfer with in_last=1 in IDLE stays in IDLE.
//  - Fixed mode (rr_en=0, IDLE):
//    - grant=sel, grant_vld = (sel<N) & in_valid[sel].
//    - sel>=N: no grant, no stall error.
//  - Round-robin mode (rr_en=1, IDLE):
//    - grant = first i with in_valid[i], scanning rr_ptr, rr_ptr+1, ... mod N.
//    - grant_vld = |in_valid.
//  - rr_ptr update: after any transfer with in_last=1, rr_ptr <= (g+1) mod N (wraps N-1 -> 0).
//    rr_ptr is unchanged otherwise, including when rr_en=0.
//  - rr_en/sel changes while in LOCK have no effect until the return to IDLE.
//  - Upstream rules: in_valid must not drop once asserted until accepted. in_data is don't-care when in_valid=0.
// STRUCTURE
//  - Shared package mips_pkg: typedef arb_state_t {IDLE, LOCK}; localparam DATA_W=32.
//  - One sub-module: rr_pick_n (N, SEL_W). Combinational rotate-priority pick from
//    in_valid and rr_ptr, producing grant and grant_vld.
//  - The top holds the FSM, the pointer, the output register and the ready generation.
// TESTING
//  1. Reset held 2 clk with in_valid=4'hF -> out_valid=0, in_ready=0; first cycle after reset, rr_en=1 -> ch0 granted.
//  2. rr_en=1, all valid, in_last=1, out_ready=1 -> out_src sequence 0,1,2,3,0; one beat/clk; data = channel payloads.
//  3. rr_en=0, sel=2, in_data[2]=32'hDEAD_BEEF -> next clk out_data=DEAD_BEEF, out_src=2; sel=3'd5 (N=4 build with SEL_W=3 override test off) / sel=2 with in_valid[2]=0 -> no in_ready.
//  4. Packet lock: ch1 sends 3 beats (last on beat 3) while ch0/ch2 valid, rr_en toggled mid-packet -> all 3 beats from ch1 consecutive, then rr_ptr=2, ch2 next.
//  5. Backpressure: out_ready=0 for 4 clk with out_valid=1 -> out_* stable, in_ready=0; release -> no beat lost or duplicated (scoreboard).
//  6. reset asserted during LOCK on ch3 -> next clk state IDLE, out_valid=0, rr_ptr=0; fresh packet from ch0 accepted normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the datapath muxing blocks.
// Holds the arbiter state encoding and the default datapath width.
package mips_pkg;

  localparam int DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick_n.sv
// Rotating-priority picker: returns the first asserted in_valid bit found
// when scanning from rr_ptr upwards, wrapping modulo N.
module rr_pick_n #(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     in_valid,
  input  logic [SEL_W-1:0] rr_ptr,
  output logic [SEL_W-1:0] grant,
  output logic             grant_vld
);

  localparam int SW1 = SEL_W + 1;

  logic [N-1:0]   rotated;
  logic [SW1-1:0] sum;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    rotated   = N'({in_valid, in_valid} >> rr_ptr);
    grant     = '0;
    grant_vld = |in_valid;
    sum       = '0;
    // Descending scan so the lowest offset from rr_ptr wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        sum   = SW1'(rr_ptr) + SW1'(k);
        grant = (sum >= SW1'(N)) ? SEL_W'(sum - SW1'(N)) : SEL_W'(sum);
      end
    end
  end

endmodule

// File: rtl/mux_arb_n.sv
// N:1 registered data mux with valid/ready handshakes, fixed or round-robin
// arbitration, and packet locking on in_last.
module mux_arb_n
  import mips_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rr_en,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_src,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready
);

  // Channel vectors padded to a power of two so an out-of-range sel reads 0.
  localparam int NP = 1 << SEL_W;

  arb_state_t       state, state_nxt;
  logic [SEL_W-1:0] lock_ch;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] ptr_nxt;
  logic [SEL_W-1:0] pick_grant;
  logic             pick_vld;
  logic [SEL_W-1:0] grant;
  logic             grant_vld;
  logic [NP-1:0]    valid_pad;
  logic [NP-1:0]    last_pad;
  logic             ld;
  logic             xfer;
  logic             xfer_last;
  logic [WIDTH-1:0] ch_data [N];

  assign valid_pad = NP'(in_valid);
  assign last_pad  = NP'(in_last);

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  rr_pick_n #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .in_valid  (in_valid),
    .rr_ptr    (rr_ptr),
    .grant     (pick_grant),
    .grant_vld (pick_vld)
  );

  // Grant selection and next-state decode.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    state_nxt = state;
    case (state)
      LOCK: begin
        grant     = lock_ch;
        grant_vld = valid_pad[lock_ch];
      end
      default: begin
        if (rr_en) begin
          grant     = pick_grant;
          grant_vld = pick_vld;
        end else begin
          grant     = sel;
          grant_vld = valid_pad[sel];
        end
      end
    endcase
    if (xfer) begin
      state_nxt = xfer_last ? IDLE : LOCK;
    end
  end

  // Output slot is free when empty or draining this cycle.
  assign ld = ~out_valid | out_ready;

  always_comb begin
    for (int g = 0; g < N; g++) begin
      in_ready[g] = ld & grant_vld & ~reset & (grant == SEL_W'(g));
    end
  end

  assign xfer      = |(in_valid & in_ready);
  assign xfer_last = last_pad[grant];
  assign ptr_nxt   = (grant == SEL_W'(N - 1)) ? '0 : grant + SEL_W'(1);

  // NOTE: all state here uses non-blocking assignment so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lock_ch   <= '0;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      out_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (xfer) begin
        lock_ch <= grant;
      end
      if (xfer && xfer_last) begin
        rr_ptr <= ptr_nxt;
      end
      if (ld) begin
        out_valid <= xfer;
        if (xfer) begin
          out_data <= ch_data[grant];
          out_src  <= grant;
          out_last <= xfer_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_arb_n.sv
// Self-checking bench for mux_arb_n: hand vector table, lock/backpressure/reset
// sequences, and randomized traffic against a transaction-level model.
module tb_mux_arb_n;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          rr_en;
  logic [SW-1:0] sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_last;
  logic [N-1:0]  in_ready;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_src;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;

  always #5 clk = ~clk;

  mux_arb_n #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .rr_en     (rr_en),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: packet ownership, next-preferred channel, output slot.
  bit         m_locked  = 0;
  int         m_lock_ch = 0;
  int         m_ptr     = 0;
  bit         m_ov      = 0;
  logic [W-1:0] m_od    = '0;
  int         m_os      = 0;
  bit         m_ol      = 0;
  logic [W-1:0] sb[$];

  typedef struct {
    bit         rr;
    logic [1:0] sel;
    logic [3:0] v;
    logic [3:0] l;
    logic [3:0] rdy;
    logic [1:0] src;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pdata(input int v, input int i);
    return 32'h5A00_0000 | (32'(v) << 8) | 32'(i);
  endfunction

  task automatic model_grant(output int g, output bit gv);
    g  = 0;
    gv = 0;
    if (m_locked) begin
      g  = m_lock_ch;
      gv = in_valid[g];
    end else if (rr_en) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (in_valid[c] && !gv) begin
          g  = c;
          gv = 1;
        end
      end
    end else begin
      g  = int'(sel);
      gv = (g < N) && in_valid[g];
    end
  endtask

  // One clock: check in_ready before the edge, advance model, check out_* after.
  task automatic step(output logic [3:0] rdy_dut, output logic [3:0] rdy_exp);
    int g;
    bit gv, ld, xfer, was_reset;
    #1;
    model_grant(g, gv);
    ld      = !m_ov || out_ready;
    rdy_exp = (!reset && ld && gv) ? 4'(1 << g) : 4'b0;
    rdy_dut = in_ready;
    check("in_ready", 32'(in_ready), 32'(rdy_exp));
    xfer = (rdy_exp != 4'b0);
    if (!reset && out_valid === 1'b1 && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard: got beat %h expected none (queue empty)", out_data);
      end else begin
        check("sb_data", out_data, sb.pop_front());
      end
    end
    was_reset = reset;
    @(posedge clk);
    if (was_reset) begin
      m_locked = 0; m_lock_ch = 0; m_ptr = 0;
      m_ov = 0; m_od = '0; m_os = 0; m_ol = 0;
      sb.delete();
    end else begin
      if (ld) begin
        m_ov = xfer;
        if (xfer) begin
          m_od = in_data[g*W +: W];
          m_os = g;
          m_ol = in_last[g];
          sb.push_back(m_od);
        end
      end
      if (xfer) begin
        if (in_last[g]) begin
          m_locked = 0;
          m_ptr    = (g + 1) % N;
        end else if (!m_locked) begin
          m_locked  = 1;
          m_lock_ch = g;
        end
      end
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov || was_reset) begin
      check("out_data", out_data, m_od);
      check("out_src", 32'(out_src), 32'(m_os));
      check("out_last", 32'(out_last), 32'(m_ol));
    end
  endtask

  task automatic drive(input bit r, input bit rr, input logic [1:0] s,
                       input logic [3:0] v, input logic [3:0] l, input bit ordy);
    reset     = r;
    rr_en     = rr;
    sel       = s;
    in_valid  = v;
    in_last   = l;
    out_ready = ordy;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish by t=%0t expected finish", $time);
    $fatal(1);
  end

  initial begin
    logic [3:0] rd, re;

    tbl[0] = '{1'b1, 2'd0, 4'hF,    4'hF,    4'b0001, 2'd0};
    tbl[1] = '{1'b1, 2'd0, 4'hF,    4'hF,    4'b0010, 2'd1};
    tbl[2] = '{1'b1, 2'd0, 4'hF,    4'hF,    4'b0100, 2'd2};
    tbl[3] = '{1'b1, 2'd0, 4'hF,    4'hF,    4'b1000, 2'd3};
    tbl[4] = '{1'b1, 2'd0, 4'hF,    4'hF,    4'b0001, 2'd0};
    tbl[5] = '{1'b1, 2'd0, 4'b1001, 4'hF,    4'b1000, 2'd3};
    tbl[6] = '{1'b0, 2'd2, 4'b0100, 4'hF,    4'b0100, 2'd2};
    tbl[7] = '{1'b0, 2'd2, 4'b1011, 4'hF,    4'b0000, 2'd0};
    tbl[8] = '{1'b1, 2'd3, 4'b0011, 4'hF,    4'b0001, 2'd0};
    tbl[9] = '{1'b0, 2'd0, 4'b0000, 4'hF,    4'b0000, 2'd0};

    // Reset held two cycles with every channel requesting.
    in_data = '0;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = pdata(99, i);
    drive(1, 1, 2'd0, 4'hF, 4'hF, 1);
    for (int c = 0; c < 2; c++) begin
      step(rd, re);
      check("rst_in_ready", 32'(rd), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
    end

    // Single-beat vector table.
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < N; i++) in_data[i*W +: W] = pdata(v, i);
      if (v == 6) in_data[2*W +: W] = 32'hDEAD_BEEF;
      drive(0, tbl[v].rr, tbl[v].sel, tbl[v].v, tbl[v].l, 1);
      step(rd, re);
      check("tbl_ready", 32'(rd), 32'(tbl[v].rdy));
      if (tbl[v].rdy != 4'b0) begin
        check("tbl_valid", 32'(out_valid), 32'd1);
        check("tbl_src", 32'(out_src), 32'(tbl[v].src));
        check("tbl_data", out_data, (v == 6) ? 32'hDEAD_BEEF : pdata(v, int'(tbl[v].src)));
      end else begin
        check("tbl_idle", 32'(out_valid), 32'd0);
      end
    end

    // Packet lock on ch1 while ch0/ch2 also request, arbitration mode flipping.
    for (int i = 0; i < N; i++) in_data[i*W +: W] = pdata(50, i);
    for (int b = 1; b <= 3; b++) begin
      in_data[1*W +: W] = 32'h1000_0000 | 32'(b);
      drive(0, (b != 2), 2'd0, 4'b0111, (b == 3) ? 4'b0111 : 4'b0101, 1);
      step(rd, re);
      check("lock_ready", 32'(rd), 32'b0010);
      check("lock_src", 32'(out_src), 32'd1);
      check("lock_data", out_data, 32'h1000_0000 | 32'(b));
      check("lock_last", 32'(out_last), (b == 3) ? 32'd1 : 32'd0);
    end
    in_data[2*W +: W] = 32'h2000_0002;
    drive(0, 1, 2'd0, 4'b0101, 4'b0111, 1);
    step(rd, re);
    check("post_lock_ready", 32'(rd), 32'b0100);
    check("post_lock_src", 32'(out_src), 32'd2);

    // Backpressure: output held, no grants, then release.
    drive(0, 1, 2'd0, 4'hF, 4'hF, 0);
    for (int c = 0; c < 4; c++) begin
      step(rd, re);
      check("stall_ready", 32'(rd), 32'd0);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_src", 32'(out_src), 32'd2);
      check("stall_data", out_data, 32'h2000_0002);
    end
    drive(0, 1, 2'd0, 4'hF, 4'hF, 1);
    step(rd, re);
    check("release_ready", 32'(rd), 32'b1000);
    check("release_src", 32'(out_src), 32'd3);

    // Move pointer to ch2, lock on ch3, then reset mid-packet.
    drive(0, 0, 2'd1, 4'b0010, 4'b0010, 1);
    step(rd, re);
    drive(0, 0, 2'd3, 4'b1000, 4'b0000, 1);
    step(rd, re);
    check("l3_ready", 32'(rd), 32'b1000);
    step(rd, re);
    check("l3_ready2", 32'(rd), 32'b1000);
    drive(1, 0, 2'd3, 4'b1000, 4'b0000, 1);
    step(rd, re);
    check("midrst_ready", 32'(rd), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    drive(0, 1, 2'd0, 4'hF, 4'hF, 1);
    step(rd, re);
    check("after_rst_ready", 32'(rd), 32'b0001);
    check("after_rst_src", 32'(out_src), 32'd0);

    // Randomized traffic, upstream holds valid/data/last until accepted.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(in_valid[i] && !re[i]) || reset) begin
          in_valid[i]       = ($urandom % 4) != 0;
          in_last[i]        = ($urandom % 3) != 0;
          in_data[i*W +: W] = $urandom;
        end
      end
      if (c % 8 == 0) rr_en = $urandom % 2;
      sel       = SW'($urandom);
      out_ready = ($urandom % 4) != 0;
      reset     = ($urandom % 200) == 0;
      step(rd, re);
    end
    check("sb_depth", 32'(sb.size()), 32'(out_valid));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
